// File: rtl/uart_rx_cmd_decoder.sv
// uart_rx_cmd_decoder: 8N1 UART receiver that turns each correctly framed
// byte into a raw byte/valid pulse and, for command bytes 0xAn / 0xBn, a
// 4-bit operand plus a one-cycle load strobe for register A or B.
//
// Output protocol: data_valid, frame_err, load_a and load_b are single-cycle
// pulses with no backpressure (there is no ready). The consumer must take
// data_out / nibble in the cycle the pulse is high. data_out and nibble hold
// their value between pulses.
module uart_rx_cmd_decoder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic [3:0] nibble,
    output logic       load_a,
    output logic       load_b,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;

    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    logic [7:0] data_out_q;
    logic [3:0] nibble_q;
    logic       data_valid_q;
    logic       frame_err_q;
    logic       load_a_q;
    logic       load_b_q;

    // Start condition: a high-to-low transition on the synchronised line.
    // Because all three line registers reset to 0, a line held low through
    // reset must first rise before a fall can be seen.
    logic start_edge_d;
    assign start_edge_d = rx_prev_q & ~rx_sync_q;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receive FSM: bit timing, deserialisation, framing check and decode,
    // with all status outputs registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            nibble_q     <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_edge_d) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // A line already back high at mid start bit is a glitch.
                        state_q <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_sync_q;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_sync_q) begin
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                            if (shift_q[7:4] == 4'hA) begin
                                nibble_q <= shift_q[3:0];
                                load_a_q <= 1'b1;
                            end else if (shift_q[7:4] == 4'hB) begin
                                nibble_q <= shift_q[3:0];
                                load_b_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign nibble     = nibble_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign load_a     = load_a_q;
    assign load_b     = load_b_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: serial frames are driven on rx, every
// output pulse is logged with its cycle number, and the log is compared
// with events predicted from the frame contents and the fixed latency
// start-of-frame -> output edge.
module tb_uart_rx_cmd_decoder;

    localparam int CPB   = 16;
    localparam int H     = CPB / 2;
    // Pin falls at cycle s; sync sees it at s+2 (t0); outputs at t0+H+9*CPB+1.
    localparam int LAT   = 2 + H + 9 * CPB + 1;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic [3:0] nibble;
    logic       load_a;
    logic       load_b;
    logic       busy;
    logic [1:0] state_dbg;

    uart_rx_cmd_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .nibble     (nibble),
        .load_a     (load_a),
        .load_b     (load_b),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic        dv;
        logic        fe;
        logic        la;
        logic        lb;
        logic [7:0]  data;
        logic [3:0]  nib;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    ev_t mon_ev;

    // Reference state: last good byte and last command operand.
    logic [7:0] ref_data = 8'h00;
    logic [3:0] ref_nib = 4'h0;

    // Monitor: every cycle with any pulse becomes one logged event.
    always @(negedge clk) begin
        if (data_valid || frame_err || load_a || load_b) begin
            mon_ev.cyc  = cyc;
            mon_ev.dv   = data_valid;
            mon_ev.fe   = frame_err;
            mon_ev.la   = load_a;
            mon_ev.lb   = load_b;
            mon_ev.data = data_out;
            mon_ev.nib  = nibble;
            obs_q.push_back(mon_ev);
        end
    end

    // Reference model: predicts the single event a frame produces.
    function automatic void model_frame(input logic [7:0] b, input logic stop_bit, input int start);
        ev_t e;
        int  hi;
        hi   = int'(b) / 16;
        e.cyc = start + LAT;
        e.dv  = stop_bit;
        e.fe  = !stop_bit;
        e.la  = 1'b0;
        e.lb  = 1'b0;
        if (stop_bit) begin
            ref_data = b;
            if (hi == 10) begin
                ref_nib = 4'(int'(b) % 16);
                e.la = 1'b1;
            end else if (hi == 11) begin
                ref_nib = 4'(int'(b) % 16);
                e.lb = 1'b1;
            end
        end
        e.data = ref_data;
        e.nib  = ref_nib;
        exp_q.push_back(e);
    endfunction

    // Driver: caller is positioned #1 after a rising edge; returns likewise,
    // with the line idle high, exactly FRAME cycles later.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic send_modeled(input logic [7:0] b, input logic stop_bit);
        model_frame(b, stop_bit, cyc);
        send_frame(b, stop_bit);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({data_out, nibble, data_valid, frame_err, load_a, load_b, busy} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h nib=%h dv=%b fe=%b la=%b lb=%b busy=%b, want all 0",
                     data_out, nibble, data_valid, frame_err, load_a, load_b, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Line held low across reset release must not start a frame.
        idle_cycles(30);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL low_after_reset_busy: got %b want 0", busy);
        end
        rx = 1'b1;
        idle_cycles(30);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL rise_after_reset: busy=%b events=%0d want busy=0 events=0", busy, obs_q.size());
        end
    endtask

    task automatic test_single_cmd();
        obs_q.delete();
        exp_q.delete();
        send_modeled(8'hA5, 1'b1);
        idle_cycles(5);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL single_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        exp_q.delete();
        send_modeled(8'hB3, 1'b1);
        send_modeled(8'hA9, 1'b1);
        idle_cycles(5);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 2) begin
            checks++;
            if (obs_q[1].cyc - obs_q[0].cyc != 32'(FRAME)) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d want %0d", obs_q[1].cyc - obs_q[0].cyc, FRAME);
            end
        end
    endtask

    task automatic test_non_cmd_and_frame_err();
        obs_q.delete();
        exp_q.delete();
        send_modeled(8'h5C, 1'b1);
        idle_cycles(3);
        send_modeled(8'hA7, 1'b0);
        idle_cycles(2);
        send_modeled(8'hB1, 1'b1);
        idle_cycles(5);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL err_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL err_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int s;
        obs_q.delete();
        s  = cyc;
        rx = 1'b0;
        idle_cycles(4);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_mid: got %b want 1 at cycle %0d", busy, cyc - s);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_end: got %b want 0 at cycle %0d", busy, cyc - s);
        end
        @(posedge clk);
        #1;
        idle_cycles(30);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_pulses: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_q.delete();
        exp_q.delete();
        fork
            send_frame(8'hF5, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #2;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL midreset_busy_before: got %b want 1", busy);
                end
                reset = 1'b1;
                @(posedge clk);
                #2;
                reset = 1'b0;
                @(negedge clk);
                checks++;
                if ({data_out, nibble, data_valid, frame_err, load_a, load_b, busy} !== 17'h0) begin
                    failures++;
                    $display("FAIL midreset_outputs: got data=%h nib=%h dv=%b fe=%b la=%b lb=%b busy=%b, want all 0",
                             data_out, nibble, data_valid, frame_err, load_a, load_b, busy);
                end
            end
        join
        ref_data = 8'h00;
        ref_nib  = 4'h0;
        idle_cycles(40);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_discard: got events=%0d busy=%b want 0 and 0", obs_q.size(), busy);
        end
        obs_q.delete();
        send_modeled(8'hA2, 1'b1);
        idle_cycles(5);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            failures++;
            $display("FAIL midreset_next_count: got %0d events want 1", obs_q.size());
        end else if (obs_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL midreset_next_ev: got %h want %h", obs_q[0], exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_bit;
        int         gap;
        obs_q.delete();
        exp_q.delete();
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 2))
                0:       b = {4'hA, 4'($urandom_range(0, 15))};
                1:       b = {4'hB, 4'($urandom_range(0, 15))};
                default: b = 8'($urandom_range(0, 255));
            endcase
            stop_bit = ($urandom_range(0, 4) != 0);
            send_modeled(b, stop_bit);
            // A low stop bit must be followed by some idle high time so the
            // next start bit presents a falling edge.
            gap = stop_bit ? $urandom_range(0, 12) : $urandom_range(2, 12);
            if (gap > 0) idle_cycles(gap);
        end
        idle_cycles(5);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_single_cmd();
        test_back_to_back();
        test_non_cmd_and_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_decoder.md
# uart_rx_cmd_decoder

Receive-side companion to the two-operand latch stage: an 8N1 UART receiver that deserialises bytes from a single serial line and decodes each byte into a 4-bit operand plus a one-cycle load strobe for register A or register B. It sits between the external serial pin and the latch stage, replacing manual save strobes with serial commands. It also exposes the raw received byte, a valid pulse and a framing-error pulse for debug and status.

## Interface

- CLKS_PER_BIT, 16, clock cycles per UART bit; integer, must be ≥ 4.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly framed byte; updates only on data_valid.
- data_valid  output  1  one-cycle pulse: new byte on data_out.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- nibble  output  4  operand from last A/B command byte (data[3:0]).
- load_a  output  1  one-cycle pulse: byte high nibble was 4'hA.
- load_b  output  1  one-cycle pulse: byte high nibble was 4'hB.
- busy  output  1  high whenever FSM is not IDLE.

## Operation

- Input: 2-FF synchronizer on rx, then a third register (rx_prev) for edge detect. All three reset to 0, so an idle-high line never produces a false start; a line held low through reset release starts nothing until it has gone high and then fallen.
- Counter: bit-timing counter with width clog2(CLKS_PER_BIT); bit index 0..7.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: when rx_prev=1 and rx_sync=0 (falling edge), clear the counter and go to START.
- START: count to H-1, where H = CLKS_PER_BIT/2 (integer division). At that mid-bit sample:
  - rx_sync=0: go to DATA with bit index 0 and counter cleared.
  - rx_sync=1: treat as a glitch and return to IDLE. No output pulses.
- DATA: count to CLKS_PER_BIT-1, then sample rx_sync into shift[index]. Bits arrive LSB first. After index 7, go to STOP.
- STOP: count to CLKS_PER_BIT-1, sample, then go to IDLE.
  - Sample = 1: data_out ← shift; assert data_valid.
  - Sample = 0: assert frame_err. data_out, nibble and the load strobes are unchanged.
- Decode happens on a valid byte only:
  - high nibble A: nibble ← byte[3:0], load_a=1.
  - high nibble B: nibble ← byte[3:0], load_b=1.
  - any other value: nibble held, no load.
  - load_a and load_b are never asserted together.
- Reset is highest priority and applies in any state:
  - FSM → IDLE, counter and index cleared, shift register cleared.
  - data_out=0, nibble=0; data_valid, frame_err, load_a, load_b, busy all 0.
  - A partially received frame is discarded.

## Timing

- t0 = first cycle with the FSM in IDLE, rx_prev=1 and rx_sync=0. rx_sync lags the pin by 2 cycles.
- busy is high from t0+1 until the cycle after the stop sample.
- Start sample at t0+H. Data bit i is sampled at t0+H+(i+1)·CLKS_PER_BIT. Stop sample at t0+H+9·CLKS_PER_BIT.
- data_valid, frame_err, load_a, load_b, data_out and nibble change at the edge after the stop sample, i.e. t0+H+9·CLKS_PER_BIT+1.
- Output pulses last exactly one cycle.
- The FSM is back in IDLE in that same cycle and can detect a new start edge immediately. Back-to-back frames with a 1-bit stop and no extra idle time must be received without loss.
- No flow control: the consumer must accept each load strobe in the cycle it is asserted.

## Test plan

- CLKS_PER_BIT=16, rx idle, send 0xA5 → data_valid and load_a pulse once, each 1 cycle wide, at t0+8+144+1; data_out=0xA5, nibble=5, load_b=0, frame_err=0.
- Send 0xB3 immediately followed by 0xA9, back-to-back with no gap → load_b with nibble=3, then load_a with nibble=9; the two valid pulses are exactly 160 cycles apart.
- Send 0x5C → data_valid pulse with data_out=0x5C; no load_a or load_b; nibble keeps its previous value.
- Send 0xA7 with the stop bit driven 0 → frame_err pulse at the stop-sample time+1; no data_valid, no load; data_out and nibble unchanged. Then send 0xB1 → received normally, nibble=1.
- Drive rx low for 4 cycles, then high → FSM returns to IDLE by t0+8; busy drops; no pulses on any output.
- Assert reset for 1 cycle during data bit 4 of a frame → all outputs 0 on the next cycle and busy=0; the remainder of that frame produces no valid byte. The next clean frame 0xA2 gives load_a with nibble=2.
